// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared defaults and helpers for the panel-input debouncer.
//   DEBOUNCE_SYNC_STAGES_DEF   : default synchroniser depth
//   DEBOUNCE_STABLE_CYCLES_DEF : default number of agreeing samples before q moves
//   cnt_width(n)               : width of a counter that must hold values 0..n
package debounce_pkg;

    localparam int DEBOUNCE_SYNC_STAGES_DEF   = 2;
    localparam int DEBOUNCE_STABLE_CYCLES_DEF = 2;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync
//   Flop-chain synchroniser for an asynchronous single-bit input.
//   Ports:
//     clk    in  sample clock, rising edge
//     rst_n  in  synchronous active-low reset, clears every stage to 0
//     d      in  asynchronous input
//     d_s    out synchronised copy of d, STAGES edges of latency
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int STAGES = DEBOUNCE_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic d_s
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_s = sync_q[STAGES-1];

endmodule

// File: rtl/debounce.sv
// debounce
//   Single-bit switch/button debouncer for the alarm-clock front panel.
//   q only moves after the synchronised input has disagreed with q for
//   STABLE_CYCLES consecutive samples; any agreeing sample restarts the count.
//   Optional feature macro: DEBOUNCE_EDGE_EN adds registered q_rise / q_fall
//   pulses; q behaves identically with or without it.
//   Ports:
//     clk     in  sample clock (10 ms), rising edge
//     rst_n   in  synchronous active-low reset
//     d       in  raw bouncy input, asynchronous to clk
//     q       out debounced level, registered
//     q_rise  out one-cycle pulse in the cycle q becomes 1 (DEBOUNCE_EDGE_EN only)
//     q_fall  out one-cycle pulse in the cycle q becomes 0 (DEBOUNCE_EDGE_EN only)
module debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEBOUNCE_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic q_rise,
    output logic q_fall
`endif
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_params
            $error("debounce: SYNC_STAGES must be >= 2 and STABLE_CYCLES >= 1");
        end
    endgenerate

    logic             d_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             q_q;
    logic             q_d;

    debounce_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .d_s   (d_s)
    );

    // The counter only ever tracks the current run of samples that disagree
    // with q, so it tops out at STABLE_CYCLES-1 and cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (d_s == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            q_d   = d_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Registered alongside q so each pulse coincides with the cycle q changes.
    always_comb begin
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q_rise = rise_q;
    assign q_fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce.sv
// tb_debounce
//   Randomised and directed stimulus for debounce with a scoreboard.
//   Time unit: 1 tick = 100 us; clk period = 100 ticks (10 ms).
//   Stimulus changes only on whole-millisecond times; clock edges sit
//   half a millisecond off that grid so d never changes on an edge.
module tb_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 2;
    localparam int MS     = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic d     = 1'b1;
    logic q;
`ifdef DEBOUNCE_EDGE_EN
    logic q_rise;
    logic q_fall;
`endif

    debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .q      (q)
`ifdef DEBOUNCE_EDGE_EN
        ,
        .q_rise (q_rise),
        .q_fall (q_fall)
`endif
    );

    initial begin
        #5;
        forever #50 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_q_fifo[$];
`ifdef DEBOUNCE_EDGE_EN
    logic exp_rise_fifo[$];
    logic exp_fall_fifo[$];
`endif

    // Reference model: the level seen inside the DUT at an edge is the value
    // of d sampled SYNC edges earlier (zero if that edge was a reset edge).
    // q adopts a new level once STABLE consecutive seen samples all differ
    // from it; an agreeing sample throws away the pending run.
    logic seen_hist[$];
    logic pending[$];
    logic m_q = 1'b0;

    always @(posedge clk) begin
        logic ds;
        logic prev;
        prev = m_q;
        if (!rst_n) begin
            seen_hist.delete();
            for (int i = 0; i < SYNC; i++) seen_hist.push_back(1'b0);
            pending.delete();
            m_q = 1'b0;
        end else begin
            ds = seen_hist[seen_hist.size() - SYNC];
            seen_hist.push_back(d);
            while (seen_hist.size() > SYNC) void'(seen_hist.pop_front());
            if (ds == m_q) begin
                pending.delete();
            end else begin
                pending.push_back(ds);
                if (pending.size() == STABLE) begin
                    m_q = ds;
                    pending.delete();
                end
            end
        end
        exp_q_fifo.push_back(m_q);
`ifdef DEBOUNCE_EDGE_EN
        exp_rise_fifo.push_back(rst_n && !prev && m_q);
        exp_fall_fifo.push_back(rst_n && prev && !m_q);
`endif
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q_fifo.size() > 0) check("q", q, exp_q_fifo.pop_front());
`ifdef DEBOUNCE_EDGE_EN
        if (exp_rise_fifo.size() > 0) check("q_rise", q_rise, exp_rise_fifo.pop_front());
        if (exp_fall_fifo.size() > 0) check("q_fall", q_fall, exp_fall_fifo.pop_front());
`endif
    end

    // Move to the next whole-millisecond time just after a falling edge;
    // the next rising edge follows 4.5 ms later.
    task automatic align();
        @(negedge clk);
        #5;
    endtask

    task automatic hold(input logic lvl, input int ms);
        d = lvl;
        #(ms * MS);
    endtask

    initial begin
        int total;
        int dt;

        // Reset held over two edges with d high; q must qualify afterwards.
        rst_n = 1'b0;
        d     = 1'b1;
        #(20 * MS);
        rst_n = 1'b1;
        hold(1'b1, 60);

        // Clean steps.
        hold(1'b0, 60);
        align();
        hold(1'b1, 40);
        hold(1'b1, 30);
        align();
        hold(1'b0, 30);
        hold(1'b0, 40);

        // Bounce then settle high.
        total = $urandom_range(10, 30);
        while (total > 0) begin
            dt = $urandom_range(1, 3);
            d  = ~d;
            #(dt * MS);
            total -= dt;
        end
        hold(1'b1, 60);

        // Single-sample glitch low while q is high.
        align();
        hold(1'b0, 8);
        hold(1'b1, 50);

        // Mid-count reset.
        hold(1'b0, 60);
        align();
        hold(1'b1, 20);
        rst_n = 1'b0;
        #(10 * MS);
        rst_n = 1'b1;
        hold(1'b1, 60);

        // Random segments, mostly short enough to be bounces, with
        // occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                #($urandom_range(1, 25) * MS);
                rst_n = 1'b1;
            end
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 45));
        end

        hold(d, 60);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(100000 * MS);
        $display("FAIL timeout at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
